// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a PSRAM controller.
// Port A (Atari bus, byte reads) and port B (loader, byte reads/writes) share
// one controller. A one-word read buffer serves repeated port-A reads of the
// same 16-bit word without touching memory.
//
// Handshake: a requester raises req with stable address/data and holds it
// until it sees a one-cycle ack (read data is valid in the ack cycle). The
// ack cycle itself never starts a new request; req still high in the cycle
// after ack is a new request. Dropping req before ack abandons the ack, but
// the memory operation already issued still runs to completion.
// Controller side: one-cycle mem_read/mem_write strobe, then mem_busy rises
// and later falls; mem_dout is captured in the first cycle mem_busy is low.
module psram_arbiter #(
  parameter int MAX_A_STREAK = 4,
  parameter bit CACHE_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic [21:0] a_addr,
  output logic        a_ack,
  output logic [7:0]  a_data,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [21:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_byte_write,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic        ready,
  output logic [1:0]  dbg_state
);

  localparam int SW = $clog2(MAX_A_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_A_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // read buffer
  logic          valid_q;
  logic [20:0]   tag_q;
  logic [15:0]   word_q;
  logic [SW-1:0] streak_q;

  // the operation currently owned by the controller
  logic        g_b_q;
  logic        g_we_q;
  logic        g_live_q;
  logic [21:0] g_addr_q;
  logic [7:0]  g_wdata_q;

  logic       a_live, b_live;
  logic       hit, grant_a, grant_b;
  logic       g_req, ack_ok, wr_match;
  logic [7:0] rd_byte, hit_byte;

  assign dbg_state = state_q;

  // Arbitration decisions and next-state logic
  always_comb begin
    state_d  = state_q;
    hit      = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    // an ack cycle must not be mistaken for a fresh request
    a_live   = a_req & ~a_ack;
    b_live   = b_req & ~b_ack;
    g_req    = g_b_q ? b_req : a_req;
    ack_ok   = g_live_q & g_req;
    rd_byte  = g_addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];
    hit_byte = a_addr[0] ? word_q[15:8] : word_q[7:0];
    wr_match = valid_q && (tag_q == g_addr_q[21:1]);
    case (state_q)
      IDLE: begin
        if (CACHE_EN && a_live && valid_q && (tag_q == a_addr[21:1])) begin
          hit = 1'b1;
        end else if (ready && !mem_busy) begin
          if (b_live && (!a_live || streak_q >= STREAK_MAX)) begin
            grant_b = 1'b1;
          end else if (a_live) begin
            grant_a = 1'b1;
          end
          if (grant_a || grant_b) state_d = ISSUE;
        end
      end
      ISSUE:   if (mem_busy)  state_d = WAIT;
      WAIT:    if (!mem_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Outputs, read buffer, streak counter and the captured grant
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_ack          <= 1'b0;
      a_data         <= 8'h00;
      b_ack          <= 1'b0;
      b_rdata        <= 8'h00;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= 22'h0;
      mem_din        <= 16'h0;
      mem_byte_write <= 1'b0;
      ready          <= 1'b0;
      valid_q        <= 1'b0;
      tag_q          <= 21'h0;
      word_q         <= 16'h0;
      streak_q       <= '0;
      g_b_q          <= 1'b0;
      g_we_q         <= 1'b0;
      g_live_q       <= 1'b0;
      g_addr_q       <= 22'h0;
      g_wdata_q      <= 8'h00;
    end else begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;

      if (!mem_busy) ready <= 1'b1;

      // A gets at most MAX_A_STREAK services in a row while B waits
      if (!b_req || grant_b) begin
        streak_q <= '0;
      end else if ((hit || grant_a) && streak_q < STREAK_MAX) begin
        streak_q <= streak_q + SW'(1);
      end

      if (hit) begin
        a_ack  <= 1'b1;
        a_data <= hit_byte;
      end

      if (grant_a || grant_b) begin
        g_b_q          <= grant_b;
        g_we_q         <= grant_b & b_we;
        g_live_q       <= 1'b1;
        g_addr_q       <= grant_b ? b_addr : a_addr;
        g_wdata_q      <= b_wdata;
        mem_addr       <= grant_b ? b_addr : a_addr;
        mem_read       <= ~(grant_b & b_we);
        mem_write      <= grant_b & b_we;
        mem_byte_write <= grant_b & b_we;
        if (grant_b && b_we) mem_din <= {b_wdata, b_wdata};
      end

      // requester gave up: finish the memory cycle silently
      if ((state_q == ISSUE || state_q == WAIT) && !g_req) g_live_q <= 1'b0;

      if (state_q == WAIT && !mem_busy) begin
        if (!g_we_q) begin
          valid_q <= 1'b1;
          tag_q   <= g_addr_q[21:1];
          word_q  <= mem_dout;
          if (g_b_q) begin
            b_ack   <= ack_ok;
            b_rdata <= rd_byte;
          end else begin
            a_ack  <= ack_ok;
            a_data <= rd_byte;
          end
        end else begin
          // keep the buffered word coherent with the written byte
          if (wr_match) begin
            if (g_addr_q[0]) word_q[15:8] <= g_wdata_q;
            else             word_q[7:0]  <= g_wdata_q;
          end
          b_ack <= ack_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a scoreboard: stimulus pushes the
// expected acks and memory commands, a monitor pops and compares them.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_req;
  logic [21:0] a_addr;
  logic        a_ack;
  logic [7:0]  a_data;
  logic        b_req;
  logic        b_we;
  logic [21:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_byte_write;
  logic [15:0] mem_dout;
  logic        mem_busy;
  logic        ready;
  logic [1:0]  dbg_state;

  logic        init_busy;
  logic        ctl_busy;
  logic [15:0] dout_val;
  int          busy_len;
  int          busy_left;
  bit          start_pending;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;
  int n_a_acks  = 0;
  int cyc = 0;

  logic [38:0] exp_cmd_q[$];  // {we, addr, din}
  logic [7:0]  exp_a_q[$];
  logic [8:0]  exp_b_q[$];    // {check_data, rdata}

  assign mem_busy = init_busy | ctl_busy;
  assign mem_dout = dout_val;

  psram_arbiter #(.MAX_A_STREAK(4), .CACHE_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_byte_write(mem_byte_write), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .ready(ready), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // controller model: busy rises the cycle after a strobe, stays high busy_len cycles
  initial begin
    ctl_busy = 1'b0;
    busy_left = 0;
    start_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write)
        check("one_outstanding", {63'b0, (start_pending || busy_left > 0)}, 64'd0);
      if (start_pending) begin
        ctl_busy = 1'b1;
        busy_left = busy_len;
        start_pending = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ctl_busy = 1'b0;
      end
      if (mem_read || mem_write) start_pending = 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [38:0] ec;
    logic [8:0]  eb;
    logic [7:0]  ea;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        n_strobes++;
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", {42'b0, mem_write, mem_read, mem_addr}, 64'd0);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd", {mem_write, mem_read, mem_byte_write, mem_addr, mem_write ? mem_din : 16'h0},
                {ec[38], ~ec[38], ec[38], ec[37:16], ec[38] ? ec[15:0] : 16'h0});
        end
      end
      if (a_ack) begin
        n_a_acks++;
        if (exp_a_q.size() == 0) begin
          check("a_ack_unexpected", 64'd1, 64'd0);
        end else begin
          ea = exp_a_q.pop_front();
          check("a_data", {56'b0, a_data}, {56'b0, ea});
        end
      end
      if (b_ack) begin
        if (exp_b_q.size() == 0) begin
          check("b_ack_unexpected", 64'd1, 64'd0);
        end else begin
          eb = exp_b_q.pop_front();
          if (eb[8]) check("b_rdata", {56'b0, b_rdata}, {56'b0, eb[7:0]});
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic a_wait(input int max, output int lat);
    int t0;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (a_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    a_req = 1'b0;
    if (lat < 0) check("a_ack_timeout", 64'd1, 64'd0);
  endtask

  task automatic a_read(input logic [21:0] addr, input logic [7:0] exp_data,
                        input bit push_cmd, input int lat_exp);
    int lat;
    exp_a_q.push_back(exp_data);
    if (push_cmd) exp_cmd_q.push_back({1'b0, addr, 16'h0});
    a_addr = addr;
    a_req = 1'b1;
    a_wait(200, lat);
    if (lat_exp >= 0) check("a_latency", 64'(lat), 64'(lat_exp));
  endtask

  task automatic b_op(input logic we, input logic [21:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp_rd, input bit push_cmd, output int lat);
    int t0;
    exp_b_q.push_back({~we, exp_rd});
    if (push_cmd) exp_cmd_q.push_back({we, addr, we ? {wdata, wdata} : 16'h0});
    b_we = we;
    b_addr = addr;
    b_wdata = wdata;
    b_req = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    b_req = 1'b0;
    if (lat < 0) check("b_ack_timeout", 64'd1, 64'd0);
  endtask

  // main sequence
  initial begin
    int lat;
    bit seen_wait;
    resetn = 1'b0;
    init_busy = 1'b1;
    busy_len = 2;
    dout_val = 16'h0;
    a_req = 1'b0;
    a_addr = 22'h0;
    b_req = 1'b0;
    b_we = 1'b0;
    b_addr = 22'h0;
    b_wdata = 8'h0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {2'b0, a_ack, b_ack, mem_read, mem_write, mem_byte_write, ready,
                            a_data, b_rdata, mem_addr, mem_din, dbg_state}, 64'd0);

    // controller busy with init for 100 cycles, A request already waiting
    resetn = 1'b1;
    dout_val = 16'h1111;
    exp_a_q.push_back(8'h11);
    exp_cmd_q.push_back({1'b0, 22'h000010, 16'h0});
    a_addr = 22'h000010;
    a_req = 1'b1;
    repeat (100) @(negedge clk);
    check("no_cmd_while_init", 64'(n_strobes), 64'd0);
    check("ready_low_while_init", {63'b0, ready}, 64'd0);
    init_busy = 1'b0;
    @(negedge clk);
    check("ready_rise", {63'b0, ready}, 64'd1);
    a_wait(200, lat);
    check("single_read_after_init", 64'(n_strobes), 64'd1);

    // miss with 10 busy cycles, then a hit on the other byte of the word
    @(negedge clk);
    busy_len = 10;
    dout_val = 16'hBEEF;
    a_read(22'h000101, 8'hBE, 1'b1, 13);
    @(negedge clk);
    a_read(22'h000100, 8'hEF, 1'b0, 1);
    check("hit_no_cmd", 64'(n_strobes), 64'd2);

    // B read loads the buffer, B write patches one lane
    @(negedge clk);
    busy_len = 2;
    dout_val = 16'h1234;
    b_op(1'b0, 22'h000100, 8'h00, 8'h34, 1'b1, lat);
    check("b_latency", 64'(lat), 64'd5);
    @(negedge clk);
    b_op(1'b1, 22'h000100, 8'h56, 8'h00, 1'b1, lat);
    @(negedge clk);
    a_read(22'h000100, 8'h56, 1'b0, 1);
    @(negedge clk);
    a_read(22'h000101, 8'h12, 1'b0, 1);
    check("lane_update_no_cmd", 64'(n_strobes), 64'd4);

    // both ports held: grant order A,A,A,A,B,A,A,A,A,B
    @(negedge clk);
    dout_val = 16'hA55A;
    for (int i = 0; i < 4; i++) exp_cmd_q.push_back({1'b0, 22'(22'h000200 + 2 * i), 16'h0});
    exp_cmd_q.push_back({1'b0, 22'h000301, 16'h0});
    for (int i = 4; i < 8; i++) exp_cmd_q.push_back({1'b0, 22'(22'h000200 + 2 * i), 16'h0});
    exp_cmd_q.push_back({1'b0, 22'h000303, 16'h0});
    fork
      begin
        for (int i = 0; i < 8; i++) a_read(22'(22'h000200 + 2 * i), 8'h5A, 1'b0, -1);
      end
      begin
        int bl;
        for (int i = 0; i < 2; i++) b_op(1'b0, 22'(22'h000301 + 2 * i), 8'h00, 8'hA5, 1'b0, bl);
      end
    join
    check("streak_cmds_done", 64'(exp_cmd_q.size()), 64'd0);

    // A drops req mid-operation: read completes, no ack, buffer still loaded
    @(negedge clk);
    busy_len = 5;
    dout_val = 16'hC0DE;
    exp_cmd_q.push_back({1'b0, 22'h000400, 16'h0});
    lat = n_a_acks;
    a_addr = 22'h000400;
    a_req = 1'b1;
    repeat (2) @(negedge clk);
    a_req = 1'b0;
    repeat (15) @(negedge clk);
    check("abandon_no_ack", 64'(n_a_acks), 64'(lat));
    check("abandon_idle", {62'b0, dbg_state}, 64'd0);
    a_read(22'h000401, 8'hC0, 1'b0, 1);

    // reset during WAIT clears outputs and the buffer
    @(negedge clk);
    busy_len = 20;
    dout_val = 16'h7777;
    exp_cmd_q.push_back({1'b0, 22'h000600, 16'h0});
    a_addr = 22'h000600;
    a_req = 1'b1;
    seen_wait = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) begin
        seen_wait = 1'b1;
        break;
      end
    end
    check("reached_wait", {63'b0, seen_wait}, 64'd1);
    resetn = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    check("reset_mid_op", {2'b0, a_ack, b_ack, mem_read, mem_write, mem_byte_write, ready,
                           a_data, b_rdata, mem_addr, mem_din, dbg_state}, 64'd0);
    resetn = 1'b1;
    a_read(22'h000400, 8'h77, 1'b1, -1);

    repeat (10) @(negedge clk);
    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter MAX_A_STREAK, default 4: the maximum number of consecutive port-A services allowed while b_req is pending.
REQ-002 SHALL have parameter CACHE_EN, default 1: enables the one-word port-A read buffer.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 a_req  in  1  Atari-bus byte read request, held until a_ack.
REQ-006 a_addr  in  22  byte address for port A, stable while a_req is high.
REQ-007 a_ack  out  1  one-cycle pulse; a_data is valid in the same cycle.
REQ-008 a_data  out  8  read byte for port A.
REQ-009 b_req  in  1  loader request, held until b_ack.
REQ-010 b_we  in  1  1 = byte write, 0 = byte read.
REQ-011 b_addr  in  22  byte address for port B.
REQ-012 b_wdata  in  8  write byte for port B.
REQ-013 b_ack  out  1  one-cycle pulse; b_rdata is valid in the same cycle for reads.
REQ-014 b_rdata  out  8  read byte for port B.
REQ-015 mem_read, mem_write  out  1 each  one-cycle command strobes to the PSRAM controller.
REQ-016 mem_addr  out  22  byte address to the controller.
REQ-017 mem_din  out  16  write word to the controller.
REQ-018 mem_byte_write  out  1  byte-write qualifier to the controller.
REQ-019 mem_dout  in  16  controller read word.
REQ-020 mem_busy  in  1  controller busy (high during init/config and operations).
REQ-021 ready  out  1  high once the controller has first been observed idle after reset.

Function
REQ-022 States SHALL be IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate and issue.
- ISSUE: wait for mem_busy=1.
- WAIT: wait for mem_busy=0.
- DONE: ack.
REQ-023 ready SHALL set on the first cycle mem_busy=0 after reset and stay set until reset; no memory command is issued while ready=0.
REQ-024 IDLE, cache hit: if CACHE_EN=1 and a_req=1 and valid=1 and tag=a_addr[21:1], then:
- a_ack pulses in the next cycle;
- no memory command is issued;
- state stays IDLE.
REQ-025 IDLE, memory grant (requires ready=1 and mem_busy=0):
- Port B is granted if b_req=1 and either a_req=0 or streak≥MAX_A_STREAK.
- Otherwise port A is granted if a_req=1 (miss).
- On grant: exactly one mem_read or mem_write pulse is driven the next cycle, with mem_addr = the granted address, and state moves to ISSUE.
REQ-026 B write SHALL drive mem_write=1, mem_byte_write=1, mem_din={b_wdata,b_wdata}; reads SHALL drive mem_read=1, mem_byte_write=0.
REQ-027 ISSUE→WAIT on mem_busy=1; WAIT→DONE on mem_busy=0, capturing mem_dout in that cycle.
REQ-028 DONE SHALL pulse the granted port's ack for one cycle, then return to IDLE.
- Read byte = mem_dout[15:8] if addr[0]=1, else mem_dout[7:0].
REQ-029 Miss-to-ack latency SHALL be 3 cycles plus the number of cycles mem_busy is high.
REQ-030 streak (width clog2(MAX_A_STREAK+1)):
- increments, saturating, on each port-A service (hit or grant) while b_req=1;
- clears on a B grant or whenever b_req=0.
REQ-031 Every completed memory read (A or B) SHALL load the buffer: word=mem_dout, tag=addr[21:1], valid=1.
REQ-032 A B write whose tag matches SHALL update only the addressed byte lane of the buffered word in DONE; valid is unchanged.
REQ-033 A request whose req drops before ack SHALL still complete its memory operation but produce no ack.
REQ-034 req high in the cycle after ack SHALL be treated as a new request.
REQ-035 At most one outstanding memory command SHALL exist at any time.

Reset
REQ-036 resetn=0 in any state, including mid-operation, SHALL set state=IDLE, all outputs=0, ready=0, valid=0, streak=0 on the next edge.

Verification
REQ-037 mem_busy held high 100 cycles after reset, a_req=1 -> no mem_read until mem_busy=0; ready rises on the first cycle mem_busy=0; then exactly one mem_read pulse.
REQ-038 A read 0x000101 with mem_dout=0xBEEF, busy 10 cycles -> a_data=0xBE; an immediate A read of 0x000100 -> a_ack 1 cycle after a_req, a_data=0xEF, no mem_read.
REQ-039 a_req and b_req held continuously with distinct addresses, MAX_A_STREAK=4 -> grant order A,A,A,A,B,A,A,A,A,B.
REQ-040 Buffer holds 0x1234 for word 0x000100; B writes 0x56 to 0x000100 -> mem_din=0x5656, mem_byte_write=1; a following A read of 0x000100 hits with a_data=0x56, and a read of 0x000101 hits with a_data=0x12.
REQ-041 resetn pulsed low during WAIT -> next cycle all outputs 0 and valid=0; a subsequent A read of the previously buffered word issues a mem_read.
